fifo_rd_stream: RTL and testbench

Read-side adapter placed directly downstream of the single-port-bank FIFO (`spram_fifo`). It drives the FIFO's `ren`, absorbs the FIFO's one-cycle registered read latency into a small prefetch buffer, and presents the data as a valid/ready stream. Consumers get full one-word-per-cycle throughput and never handle `ren`/`empty` timing themselves.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/stream_buf.sv | 70 +++++++
 rtl/fifo_rd_stream.sv | 71 +++++++
 tb/tb_fifo_rd_stream.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks.
package fifo_pkg;

    // Registered read latency of the upstream spram_fifo; the read adapter
    // is built around exactly one cycle between ren and valid rdata.
    localparam int FIFO_RD_LATENCY = 1;

    // Width needed to count 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_buf.sv
// Small circular prefetch store: push writes at wr_ptr, pop advances rd_ptr,
// occ tracks the number of held words. Head word is always on dout.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int LVL_WIDTH  = lvl_width(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [LVL_WIDTH-1:0]  occ
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_WIDTH-1:0]  occ_q;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage: cleared on reset so the head word reads 0 when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves occ alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + LVL_WIDTH'(1);
                2'b01:   occ_q <= occ_q - LVL_WIDTH'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Head word and occupancy straight from registers.
    always_comb begin
        dout = mem[rd_ptr];
        occ  = occ_q;
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for spram_fifo: issues ren on credit, absorbs the
// one-cycle read latency in a prefetch buffer, presents a valid/ready stream.
//
// Output handshake: a word transfers on a rising edge where m_valid and
// m_ready are both high. m_valid never depends on m_ready, and once raised
// m_valid and m_data stay stable until the transfer happens.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int LVL_WIDTH  = lvl_width(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_ren,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LVL_WIDTH-1:0]  level
);

    // The credit scheme only covers a single cycle of read latency, and one
    // word per cycle needs a slot for the held word plus the in-flight one.
    if (FIFO_RD_LATENCY != 1 || BUF_DEPTH < 2) begin : g_bad_cfg
        $error("fifo_rd_stream: needs FIFO_RD_LATENCY == 1 and BUF_DEPTH >= 2");
    end

    logic                 inflight;
    logic                 pop;
    logic [LVL_WIDTH-1:0] occ;
    logic [LVL_WIDTH:0]   credit;

    // Credit check: words held plus the one landing this edge, minus the one
    // leaving, must leave room for the word a new ren would bring next cycle.
    always_comb begin
        m_valid  = (occ != '0);
        pop      = m_valid && m_ready;
        credit   = {1'b0, occ}
                 + {{LVL_WIDTH{1'b0}}, inflight}
                 - {{LVL_WIDTH{1'b0}}, pop};
        fifo_ren = rst_n && !fifo_empty && (credit < (LVL_WIDTH + 1)'(BUF_DEPTH));
        level    = occ;
    end

    // inflight marks that fifo_rdata carries a real word this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_ren;
        end
    end

    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .LVL_WIDTH  (LVL_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_rdata),
        .dout  (m_data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural upstream FIFO with one-cycle read
// latency, table-driven reset/first-word vectors, hand-written sequences,
// and an in-order scoreboard on the output stream.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BD = 2;
    localparam int LW = 2;

    logic          clk;
    logic          rst_n;
    logic          fifo_ren;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [LW-1:0] level;

    int total;
    int bad;

    // upstream FIFO model
    logic [DW-1:0] up_mem [256];
    int            wr_idx;
    int            rd_idx;
    logic          up_flush;

    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic          rst_n;
        logic          m_ready;
        logic          exp_ren;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [LW-1:0] exp_level;
    } vec_t;

    vec_t tbl [7];

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD),
        .LVL_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_ren   (fifo_ren),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // upstream FIFO: registered read, optional flush while in reset
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (!rst_n) begin
            fifo_rdata <= '0;
            if (up_flush) rd_idx <= wr_idx;
        end else if (fifo_ren) begin
            fifo_rdata <= up_mem[rd_idx % 256];
            rd_idx     <= rd_idx + 1;
        end
    end

    initial begin
        rd_idx = 0;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        up_mem[wr_idx % 256] = w;
        wr_idx = wr_idx + 1;
        exp_q.push_back(w);
    endtask

    // scoreboard and invariants, evaluated at the falling edge
    task automatic monitor();
        logic [DW-1:0] e;
        if (!rst_n) return;
        if (fifo_empty) check("ren_while_empty", {31'd0, fifo_ren}, 32'd0);
        total++;
        if (level > LW'(BD)) begin
            bad++;
            $display("FAIL occ_bound: got %0d expected <= %0d", level, BD);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h expected none", m_data);
            end else begin
                e = exp_q.pop_front();
                check("data_order", {24'd0, m_data}, {24'd0, e});
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        m_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            sample();
            advance();
            n++;
        end
        check(name, exp_q.size(), 0);
        sample();
        check({name, "_valid"}, {31'd0, m_valid}, 32'd0);
        check({name, "_level"}, {30'd0, level}, 32'd0);
        advance();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int first_seen;
        int vcount;
        int bubbles;
        int ren_count;
        int k;

        total    = 0;
        bad      = 0;
        wr_idx   = 0;
        rst_n    = 1'b0;
        m_ready  = 1'b1;
        up_flush = 1'b0;

        // reset held low with A5 waiting upstream, then first-word timing
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

        push_word(8'hA5);
        advance();

        for (int i = 0; i < 7; i++) begin
            rst_n   = tbl[i].rst_n;
            m_ready = tbl[i].m_ready;
            @(negedge clk);
            check($sformatf("vec%0d_ren", i),   {31'd0, fifo_ren}, {31'd0, tbl[i].exp_ren});
            check($sformatf("vec%0d_valid", i), {31'd0, m_valid},  {31'd0, tbl[i].exp_valid});
            check($sformatf("vec%0d_data", i),  {24'd0, m_data},   {24'd0, tbl[i].exp_data});
            check($sformatf("vec%0d_level", i), {30'd0, level},    {30'd0, tbl[i].exp_level});
            monitor();
            advance();
        end
        check("vec_sb_empty", exp_q.size(), 0);

        // streaming: 20 words, full throughput after the 2-cycle latency
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word(DW'(i));
        first_seen = -1;
        vcount     = 0;
        bubbles    = 0;
        for (int c = 0; c < 40; c++) begin
            sample();
            if (m_valid) begin
                if (first_seen < 0) first_seen = c;
                vcount++;
            end else if (first_seen >= 0 && c < first_seen + 20) begin
                bubbles++;
            end
            advance();
        end
        check("stream_latency", first_seen, 2);
        check("stream_count", vcount, 20);
        check("stream_bubbles", bubbles, 0);
        check("stream_sb_empty", exp_q.size(), 0);

        // backpressure: only BUF_DEPTH reads, head held at word 0
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_word(DW'(i));
        ren_count = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (fifo_ren) ren_count++;
            if (c >= 2) begin
                check("bp_valid", {31'd0, m_valid}, 32'd1);
                check("bp_hold", {24'd0, m_data}, 32'd0);
            end
            advance();
        end
        check("bp_ren_pulses", ren_count, 2);
        @(negedge clk);
        check("bp_level", {30'd0, level}, 32'd2);
        advance();
        drain("bp_drain", 40);

        // random ready and random upstream fill
        for (int c = 0; c < 400; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0 && (wr_idx - rd_idx) < 200) begin
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) push_word(DW'($urandom_range(0, 255)));
            end
            sample();
            advance();
        end
        drain("rand_drain", 600);

        // reset with one word held and one in flight (occ+inflight is capped
        // at BUF_DEPTH, so this is the fullest in-flight case)
        m_ready  = 1'b0;
        up_flush = 1'b1;
        for (int i = 0; i < 5; i++) push_word(DW'(8'h50 + i));
        sample();
        check("mr_ren0", {31'd0, fifo_ren}, 32'd1);
        advance();
        sample();
        check("mr_ren1", {31'd0, fifo_ren}, 32'd1);
        advance();
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_level_before", {30'd0, level}, 32'd1);
        check("mr_ren_in_reset", {31'd0, fifo_ren}, 32'd0);
        advance();
        rst_n = 1'b1;
        exp_q.delete();
        sample();
        check("mr_valid_after", {31'd0, m_valid}, 32'd0);
        check("mr_level_after", {30'd0, level}, 32'd0);
        advance();
        up_flush = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DW'(8'h60 + i));
        drain("mr_drain", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
